div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative 32-bit radix-2 integer divider for the LoongArch pipeline.
- Acts as the responder on the EX-stage divide request channel: accepts one request (op + two operands), computes quotient or remainder, and returns it on a response channel consumed by MEM.
- Non-pipelined: at most one division in flight.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, restoring iterations per division; must equal XLEN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  divide request valid from EX.
- req_ready  out  1  divider can accept a request.
- req_op  in  4  one-hot op: bit0 DIV.W, bit1 MOD.W, bit2 DIV.WU, bit3 MOD.WU.
- req_src1  in  32  dividend.
- req_src2  in  32  divisor.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_result  out  32  quotient or remainder per latched op.
- busy  out  1  a request is accepted and its response has not yet been handshaken.

Behaviour:
- Reset: one clock, clk; reset is synchronous and active-high on rst.
  - At reset: state=IDLE, req_ready=0 while rst=1, resp_valid=0, resp_result=0, busy=0, iteration counter=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - req_ready=1 (gated by !rst).
  - req_valid&req_ready at edge T latches op, sign flags and operand magnitudes, clears the counter, and moves to BUSY.
  - req_op is one-hot. A zero or multi-hot op is undefined and is not tested.
- BUSY:
  - One restoring step per edge: shift {rem,quo} left 1 and trial-subtract the divisor; if there is no borrow, set quotient bit and keep the difference.
  - Counter increments each step. After step ITER-1 (edge T+32), the state moves to DONE.
  - The final sign-corrected result is registered into resp_result on that edge.
  - resp_valid is first high in the cycle after edge T+32, i.e. 32-cycle latency from accept.
- DONE:
  - resp_valid=1. resp_result is held stable until resp_valid&resp_ready.
  - On handshake: return to IDLE and clear resp_valid on that edge.
  - No new request is accepted in the same cycle as the handshake; req_ready=0 in DONE.
- req_ready=0 and busy=1 in BUSY and DONE.
- Signed ops (DIV.W/MOD.W):
  - Divide absolute values.
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
  - Unsigned ops divide the raw values.
- Overflow: 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0, as the natural result of the algorithm.
- Divide by zero is deterministic:
  - Unsigned: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed: quotient 0xFFFFFFFF if the dividend is non-negative, else 0x00000001; remainder = dividend.
- rst asserted mid-operation (BUSY or DONE): abort, return to IDLE, drop resp_valid on that edge, discard the result.
- Input changes on req_* outside the accept cycle have no effect.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined: in IDLE, an accepted request with req_src2==0 skips BUSY and enters DONE at the accept edge, so resp_valid is high in the cycle after accept, with the same divide-by-zero values as above.
- Undefined: divide by zero takes the full 32-cycle path. Results are identical either way; only latency differs.

Decomposition:
- Shared package div_pkg:
  - op bit indices: DIV_OP_DIVW=0, DIV_OP_MODW=1, DIV_OP_DIVWU=2, DIV_OP_MODWU=3.
  - state enum: IDLE/BUSY/DONE.
  - DIV_ITER=32.
- One natural combinational sub-module, div_step: takes {rem,quo} and divisor, returns the next {rem,quo}. Instantiated once inside div_unit.

Test Plan:
- DIV.W src1=0xFFFFFFF9 (−7), src2=2 → resp_result=0xFFFFFFFD. MOD.W same operands → 0xFFFFFFFF. Each resp_valid rises exactly 32 cycles after accept.
- DIV.WU 0xFFFFFFFF/2 → 0x7FFFFFFF. MOD.WU same operands → 0x00000001. Signed DIV.W of the same operands → 0x00000000.
- DIV.W 0x80000000/0xFFFFFFFF → 0x80000000. MOD.W same operands → 0x00000000.
- DIV.WU 7/0 → 0xFFFFFFFF and MOD.WU 7/0 → 7. Latency is 32 cycles without DIV_ZERO_FAST_EN and 1 cycle with it. DIV.W 0xFFFFFFF9/0 → 0x00000001.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid → resp_result and resp_valid stay stable, req_ready stays 0. Raise resp_ready → return to IDLE, and a back-to-back request is accepted the following cycle.
- Assert rst for 1 cycle 10 cycles into BUSY → resp_valid never rises, req_ready=1 the cycle after rst falls, and a fresh 100/7 DIV.WU then returns 0x0000000E.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative radix-2 divider: op encoding, FSM states
// and sign helpers.
package div_pkg;

    localparam int DIV_XLEN = 32;
    localparam int DIV_ITER = 32;

    localparam int DIV_OP_DIVW  = 0;
    localparam int DIV_OP_MODW  = 1;
    localparam int DIV_OP_DIVWU = 2;
    localparam int DIV_OP_MODWU = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Two's-complement negate when neg is set; used for both magnitude and sign fix-up.
    function automatic logic [DIV_XLEN-1:0] div_neg_if(input logic neg, input logic [DIV_XLEN-1:0] val);
        logic [DIV_XLEN-1:0] res;
        if (neg) begin
            res = ~val + {{(DIV_XLEN-1){1'b0}}, 1'b1};
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/div_if.sv
// Divide request/response channel between EX (request), the divider and MEM (response).
interface div_if;
    import div_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [3:0]          req_op;
    logic [DIV_XLEN-1:0] req_src1;
    logic [DIV_XLEN-1:0] req_src2;
    logic                resp_valid;
    logic                resp_ready;
    logic [DIV_XLEN-1:0] resp_result;
    logic                busy;

    modport master (
        output req_valid, req_op, req_src1, req_src2, resp_ready,
        input  req_ready, resp_valid, resp_result, busy
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, resp_ready,
        output req_ready, resp_valid, resp_result, busy
    );

endinterface

// File: rtl/div_step.sv
// One restoring division step on unsigned magnitudes: shift {rem,quo} left and
// keep the trial difference when the divisor fits.
module div_step
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted_s;
    logic          fits_s;

    // Trial subtract; the difference always fits XLEN bits when the divisor fits.
    always_comb begin
        shifted_s = {rem, quo[XLEN-1]};
        fits_s    = (shifted_s >= {1'b0, divisor});
        if (fits_s) begin
            rem_next = shifted_s[XLEN-1:0] - divisor;
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shifted_s[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit radix-2 restoring divider (DIV.W/MOD.W/DIV.WU/MOD.WU), one op in flight.
// Optional DIV_ZERO_FAST_EN: a zero divisor bypasses the iteration and answers next cycle.
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN,
    parameter int ITER = DIV_ITER
) (
    input logic  clk,
    input logic  rst,
    div_if.slave bus
);

    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    div_state_e       state_r;
    div_state_e       state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [XLEN-1:0]  rem_r;
    logic [XLEN-1:0]  quo_r;
    logic [XLEN-1:0]  divisor_r;
    logic             is_mod_r;
    logic             quo_neg_r;
    logic             rem_neg_r;
    logic [XLEN-1:0]  result_r;

    logic             accept_s;
    logic             step_last_s;
    logic             signed_s;
    logic             is_mod_s;
    logic             src1_neg_s;
    logic             src2_neg_s;
    logic [XLEN-1:0]  src1_abs_s;
    logic [XLEN-1:0]  src2_abs_s;
    logic [XLEN-1:0]  rem_step_s;
    logic [XLEN-1:0]  quo_step_s;
    logic [XLEN-1:0]  final_s;
`ifdef DIV_ZERO_FAST_EN
    logic             src2_zero_s;
    logic [XLEN-1:0]  zero_res_s;
`endif

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (divisor_r),
        .rem_next (rem_step_s),
        .quo_next (quo_step_s)
    );

    // Decode the request on the bus into sign flags and operand magnitudes.
    always_comb begin
        signed_s   = (bus.req_op[DIV_OP_DIVW] | bus.req_op[DIV_OP_MODW]) &
                     ~(bus.req_op[DIV_OP_DIVWU] | bus.req_op[DIV_OP_MODWU]);
        is_mod_s   = bus.req_op[DIV_OP_MODW] | bus.req_op[DIV_OP_MODWU];
        src1_neg_s = signed_s & bus.req_src1[XLEN-1];
        src2_neg_s = signed_s & bus.req_src2[XLEN-1];
        src1_abs_s = div_neg_if(src1_neg_s, bus.req_src1);
        src2_abs_s = div_neg_if(src2_neg_s, bus.req_src2);
    end

`ifdef DIV_ZERO_FAST_EN
    assign src2_zero_s = (bus.req_src2 == {XLEN{1'b0}});

    // Same values the iterative path produces for a zero divisor.
    always_comb begin
        if (is_mod_s) begin
            zero_res_s = bus.req_src1;
        end else if (src1_neg_s) begin
            zero_res_s = {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            zero_res_s = {XLEN{1'b1}};
        end
    end
`endif

    // Sign-correct the last step's output; remainder follows the dividend's sign.
    always_comb begin
        if (is_mod_r) begin
            final_s = div_neg_if(rem_neg_r, rem_step_s);
        end else begin
            final_s = div_neg_if(quo_neg_r, quo_step_s);
        end
    end

    // Next-state logic for IDLE -> BUSY -> DONE -> IDLE.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        step_last_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    accept_s     = 1'b1;
`ifdef DIV_ZERO_FAST_EN
                    if (src2_zero_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = BUSY;
                    end
`else
                    state_next_s = BUSY;
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == CNT_LAST) begin
                    step_last_s  = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register; reset aborts any division in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: latch operands on accept, iterate in BUSY, capture the result on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            rem_r     <= {XLEN{1'b0}};
            quo_r     <= {XLEN{1'b0}};
            divisor_r <= {XLEN{1'b0}};
            is_mod_r  <= 1'b0;
            quo_neg_r <= 1'b0;
            rem_neg_r <= 1'b0;
            result_r  <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        cnt_r     <= {CNT_W{1'b0}};
                        rem_r     <= {XLEN{1'b0}};
                        quo_r     <= src1_abs_s;
                        divisor_r <= src2_abs_s;
                        is_mod_r  <= is_mod_s;
                        quo_neg_r <= src1_neg_s ^ src2_neg_s;
                        rem_neg_r <= src1_neg_s;
`ifdef DIV_ZERO_FAST_EN
                        if (src2_zero_s) begin
                            result_r <= zero_res_s;
                        end
`endif
                    end
                end
                BUSY: begin
                    rem_r <= rem_step_s;
                    quo_r <= quo_step_s;
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (step_last_s) begin
                        result_r <= final_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready   = (state_r == IDLE) & ~rst;
    assign bus.resp_valid  = (state_r == DONE);
    assign bus.busy        = (state_r != IDLE);
    assign bus.resp_result = result_r;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table driven through a result scoreboard,
// plus backpressure and mid-operation reset sequences.
module tb_div_unit;
    import div_pkg::*;

    localparam logic [3:0] OP_DIVW  = 4'b0001;
    localparam logic [3:0] OP_MODW  = 4'b0010;
    localparam logic [3:0] OP_DIVWU = 4'b0100;
    localparam logic [3:0] OP_MODWU = 4'b1000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    div_if bus ();

    div_unit #(.XLEN(32), .ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Posedges from the accept edge to the edge that raises resp_valid.
    function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) return 0;
`endif
        return 32;
    endfunction

    function automatic logic [3:0] rand_op();
        logic [3:0] one = 4'b0001;
        return one << $urandom_range(3, 0);
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic drive_accept(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int w = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_src1  = a;
        bus.req_src2  = b;
        while (!bus.req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) check({name, "_accept_timeout"}, {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_op    = rand_op();
        bus.req_src1  = $urandom;
        bus.req_src2  = $urandom;
    endtask

    // Called at the negedge after accept; returns at the negedge where resp_valid is seen.
    task automatic wait_resp();
        int   edges = 0;
        exp_t e;
        while (!bus.resp_valid && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            if (edges >= 100) begin
                check({e.name, "_resp_timeout"}, {31'd0, bus.resp_valid}, 32'd1);
            end else begin
                check({e.name, "_result"}, bus.resp_result, e.res);
                check({e.name, "_latency"}, edges, e.lat);
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        drive_accept(v.name, v.op, v.a, v.b);
        e.name = v.name;
        e.res  = v.res;
        e.lat  = exp_lat(v.b);
        sb_q.push_back(e);
        wait_resp();
        @(posedge clk);
        @(negedge clk);
        check({v.name, "_after_hs"}, {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   seen;

        vecs.push_back('{"divw_m7_2",      OP_DIVW,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD});
        vecs.push_back('{"modw_m7_2",      OP_MODW,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF});
        vecs.push_back('{"divwu_max_2",    OP_DIVWU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h7FFF_FFFF});
        vecs.push_back('{"modwu_max_2",    OP_MODWU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001});
        vecs.push_back('{"divw_m1_2",      OP_DIVW,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0000});
        vecs.push_back('{"divw_ovf",       OP_DIVW,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{"modw_ovf",       OP_MODW,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{"divwu_7_0",      OP_DIVWU, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF});
        vecs.push_back('{"modwu_7_0",      OP_MODWU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007});
        vecs.push_back('{"divw_m7_0",      OP_DIVW,  32'hFFFF_FFF9, 32'h0000_0000, 32'h0000_0001});
        vecs.push_back('{"modw_m7_0",      OP_MODW,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9});
        vecs.push_back('{"divw_7_0",       OP_DIVW,  32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF});
        vecs.push_back('{"divw_100_m7",    OP_DIVW,  32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2});
        vecs.push_back('{"modw_100_m7",    OP_MODW,  32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002});
        vecs.push_back('{"modw_m100_7",    OP_MODW,  32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE});
        vecs.push_back('{"divwu_big_4k",   OP_DIVWU, 32'h1234_5678, 32'h0000_1000, 32'h0001_2345});
        vecs.push_back('{"modwu_big_4k",   OP_MODWU, 32'h1234_5678, 32'h0000_1000, 32'h0000_0678});

        bus.req_valid  = 1'b0;
        bus.req_op     = OP_DIVWU;
        bus.req_src1   = 32'd0;
        bus.req_src2   = 32'd0;
        bus.resp_ready = 1'b1;

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_flags", {29'd0, bus.req_ready, bus.resp_valid, bus.busy}, 32'd0);
        check("reset_result", bus.resp_result, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: result and flags hold while resp_ready is low.
        bus.resp_ready = 1'b0;
        drive_accept("bp_divwu", OP_DIVWU, 32'd100, 32'd7);
        e.name = "bp_divwu"; e.res = 32'h0000_000E; e.lat = 32;
        sb_q.push_back(e);
        wait_resp();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_flags", {29'd0, bus.resp_valid, bus.req_ready, bus.busy}, 32'd5);
            check("bp_hold_result", bus.resp_result, 32'h0000_000E);
        end
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_op     = OP_MODWU;
        bus.req_src1   = 32'd100;
        bus.req_src2   = 32'd7;
        check("bp_no_accept_in_done", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("bp_idle_after_hs", {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
        @(posedge clk);
        e.name = "b2b_modwu"; e.res = 32'h0000_0002; e.lat = 32;
        sb_q.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_src1  = $urandom;
        bus.req_src2  = $urandom;
        wait_resp();
        @(posedge clk);
        @(negedge clk);

        // Reset mid-BUSY aborts the division.
        drive_accept("abort", OP_DIVWU, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_reset", {29'd0, bus.req_ready, bus.resp_valid, bus.busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_ready_after", {31'd0, bus.req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.resp_valid) seen++;
            @(negedge clk);
        end
        check("abort_no_resp", seen, 32'd0);
        run_vec('{"post_abort_divwu", OP_DIVWU, 32'd100, 32'd7, 32'h0000_000E});

        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
